// File: rtl/aes_pkg.sv
// Shared types and byte-level helpers for the iterative AES encryption engine.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [3:0]   rk_idx_t;

  // Controller state. Every state except IDLE counts as busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  // Forward AES S-box, indexed by the input byte value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Byte k of the state lives at bits [127-8k -: 8]; k = row + 4*column.
  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// MixColumns over all four columns of the AES state (combinational).
module aes_mixcolumns (
  input  logic [127:0] state,
  output logic [127:0] mixed
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 top to bottom; multiply by the fixed {02,03,01,01} circulant.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Each 32-bit column is transformed independently.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_col(state[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_round_dp.sv
// One full AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         final_rnd,
  output logic [127:0] next_state
);

  logic [127:0] subbed;
  logic [127:0] shifted;
  logic [127:0] mixed;

  // Sixteen parallel S-box lookups.
  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[8*i +: 8] = sbox(state[8*i +: 8]);
    end
  end

  assign shifted = shift_rows(subbed);

  aes_mixcolumns u_mixcolumns (
    .state (shifted),
    .mixed (mixed)
  );

  // The last round of AES skips MixColumns.
  assign next_state = (final_rnd ? shifted : mixed) ^ rk;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES encryption controller: one round per clock, external key store.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_block holds still until out_ready completes the transfer.
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_block,
  output logic [RKW-1:0] rk_idx,
  input  logic [127:0]   rk,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_block,
  output logic           busy
);

  fsm_state_t     fsm_state;
  fsm_state_t     fsm_next;
  logic [127:0]   state_reg;
  logic [RKW-1:0] round_cnt;
  logic           final_rnd;
  logic [127:0]   dp_next;

  aes_round_dp u_round_dp (
    .state      (state_reg),
    .rk         (rk),
    .final_rnd  (final_rnd),
    .next_state (dp_next)
  );

  // Next-state and handshake/key-index outputs, decoded from the current state.
  always_comb begin
    fsm_next  = fsm_state;
    rk_idx    = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    final_rnd = 1'b0;
    case (fsm_state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) fsm_next = ROUND;
      end
      ROUND: begin
        rk_idx = round_cnt;
        if (round_cnt == RKW'(NR - 1)) fsm_next = FINAL;
      end
      FINAL: begin
        rk_idx    = RKW'(NR);
        final_rnd = 1'b1;
        fsm_next  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // State register, round counter and FSM; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      state_reg <= '0;
      round_cnt <= '0;
    end else begin
      fsm_state <= fsm_next;
      case (fsm_state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_block ^ rk;
            round_cnt <= RKW'(1);
          end
        end
        ROUND: begin
          state_reg <= dp_next;
          round_cnt <= round_cnt + RKW'(1);
        end
        FINAL: state_reg <= dp_next;
        DONE: begin
          if (out_ready) round_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Ciphertext is only meaningful while out_valid is high.
  assign out_block = state_reg;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: FIPS-197 vectors, latency, backpressure,
// busy-time input, mid-round reset and back-to-back blocks.
module tb_aes_enc_round_ctrl;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R2_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NR=10) ----------------
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [127:0] in_block = '0, rk, out_block;
  logic [3:0]   rk_idx;

  aes_enc_round_ctrl #(.NR(10), .RKW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  // ---------------- DUT (NR=14) ----------------
  logic         in_valid14 = 1'b0, in_ready14, out_valid14, out_ready14 = 1'b0, busy14;
  logic [127:0] in_block14 = '0, rk14, out_block14;
  logic [3:0]   rk_idx14;

  aes_enc_round_ctrl #(.NR(14), .RKW(4)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
    .in_block(in_block14), .rk_idx(rk_idx14), .rk(rk14), .out_valid(out_valid14),
    .out_ready(out_ready14), .out_block(out_block14), .busy(busy14)
  );

  // ---------------- key-store model ----------------
  logic [7:0]   sb [256];
  logic [127:0] rk_a [16];
  logic [127:0] rk_b [16];
  assign rk   = rk_a[rk_idx];
  assign rk14 = rk_b[rk_idx14];

  // ---------------- scoreboard / counters ----------------
  logic [127:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0, acc_cnt = 0, last_acc = 0, last_hs = 0;

  // Observe accepts and output handshakes of the NR=10 instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (rst_n && out_valid && out_ready) last_hs <= cyc;
  end

  // ---------------- reference helpers (bench-side AES) ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse plus the affine transform.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r = inv;
      s = inv;
      repeat (4) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sb[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; nk = 4 or 8 words.
  task automatic expand_key(input logic [255:0] key, input int nk, input int nr, input bit to_b);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r2 = 0; r2 <= nr; r2++) begin
      if (to_b) rk_b[r2] = {w[4*r2], w[4*r2+1], w[4*r2+2], w[4*r2+3]};
      else      rk_a[r2] = {w[4*r2], w[4*r2+1], w[4*r2+2], w[4*r2+3]};
    end
  endtask

  // Byte-array AES-128 encryption using the rk_a table.
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_a[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_a[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  // Wait for in_ready, present one block for one accepting edge, record its ciphertext.
  task automatic send_block(input logic [127:0] pt, input logic [127:0] ct);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_block = pt;
    exp_q.push_back(ct);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = rand128();
  endtask

  // Wait (bounded) for out_valid; n = cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Complete one output handshake; got = block presented at the handshake edge.
  task automatic take_output(output logic [127:0] got);
    out_ready = 1'b1;
    got = out_block;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0 || out_block !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b rk_idx=%0d out_block=%h required 1 0 0 0 0",
               in_ready, out_valid, busy, rk_idx, out_block);
    end
    checks++;
    if (out_valid14 !== 1'b0 || in_ready14 !== 1'b1 || busy14 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state14: out_valid=%b in_ready=%b busy=%b required 0 1 0", out_valid14, in_ready14, busy14);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_b();
    logic [127:0] got, exp;
    expand_key({KEY_B, 128'h0}, 4, 10, 1'b0);
    send_block(PT_B, CT_B);
    checks++;
    if (rk_idx !== 4'd1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fips_b_first_round: rk_idx=%0d in_ready=%b busy=%b required 1 0 1", rk_idx, in_ready, busy);
    end
    // Rounds 2..9 then FINAL (rk_idx 10); out_valid must not rise before.
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        checks++;
        if (dut.state_reg !== R2_B) begin
          errors++;
          $display("FAIL fips_b_round1_state: state_reg=%h required %h", dut.state_reg, R2_B);
        end
      end
      checks++;
      if (rk_idx !== 4'(k) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fips_b_rk_idx: rk_idx=%0d out_valid=%b required %0d 0", rk_idx, out_valid, k);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fips_b_latency: out_valid=%b busy=%b in_ready=%b 10 edges after accept, required 1 1 0",
               out_valid, busy, in_ready);
    end
    take_output(got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL fips_b_ct: out_block=%h required %h", got, exp);
    end
  endtask

  task automatic test_fips_c1();
    logic [127:0] got, exp;
    int n;
    expand_key({KEY_C1, 128'h0}, 4, 10, 1'b0);
    send_block(PT_C, CT_C1);
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fips_c1_timeout: out_valid=%b required 1", out_valid);
    end
    take_output(got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL fips_c1_ct: out_block=%h required %h", got, exp);
    end
  endtask

  task automatic test_aes256();
    logic [127:0] got, exp;
    int n;
    expand_key(KEY_C3, 8, 14, 1'b1);
    in_valid14 = 1'b1;
    in_block14 = PT_C;
    exp_q.push_back(CT_C3);
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    in_block14 = rand128();
    n = 0;
    while (out_valid14 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL aes256_latency: edges to out_valid=%0d required 14", n);
    end
    out_ready14 = 1'b1;
    got = out_block14;
    @(posedge clk); #1;
    out_ready14 = 1'b0;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL aes256_ct: out_block=%h required %h", got, exp);
    end
    checks++;
    if (out_valid14 !== 1'b0 || in_ready14 !== 1'b1) begin
      errors++;
      $display("FAIL aes256_drain: out_valid=%b in_ready=%b required 0 1", out_valid14, in_ready14);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] first, got, exp;
    int n;
    send_block(PT_C, CT_C1);
    wait_out(n);
    first = out_block;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_block !== first || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d out_valid=%b out_block=%h in_ready=%b required 1 %h 0",
                 i, out_valid, out_block, in_ready, first);
      end
    end
    take_output(got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL backpressure_ct: out_block=%h required %h", got, exp);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_input();
    logic [127:0] got, exp;
    int acc0, n;
    expand_key({KEY_B, 128'h0}, 4, 10, 1'b0);
    acc0 = acc_cnt;
    send_block(PT_B, CT_B);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      in_valid = ~in_valid;
      in_block = rand128();
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    take_output(got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL busy_input_ct: out_block=%h required %h", got, exp);
    end
    checks++;
    if (acc_cnt - acc0 != 1) begin
      errors++;
      $display("FAIL busy_input_accepts: accepted=%0d required 1", acc_cnt - acc0);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, exp;
    int n;
    send_block(PT_B, CT_B);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || rk_idx !== 4'd0 || out_block !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid_state: out_valid=%b busy=%b in_ready=%b rk_idx=%0d out_block=%h required 0 0 1 0 0",
               out_valid, busy, in_ready, rk_idx, out_block);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale: cycle %0d out_valid=%b busy=%b required 0 0", i, out_valid, busy);
      end
    end
    send_block(PT_B, CT_B);
    wait_out(n);
    take_output(got);
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_ct: out_block=%h required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt2, got, exp;
    int n, acc0, hs1;
    pt2  = rand128();
    acc0 = acc_cnt;
    hs1  = 0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: in_ready=%b required 1", in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_block  = PT_B;
    exp_q.push_back(CT_B);
    @(posedge clk); #1;
    in_block = pt2;
    exp_q.push_back(ref_encrypt(pt2));
    for (int blk = 0; blk < 2; blk++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      got = out_block;
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_ct%0d: out_block=%h required %h", blk, got, exp);
      end
      @(posedge clk); #1;
      if (blk == 0) begin
        hs1 = last_hs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (last_acc != hs1 + 1) begin
          errors++;
          $display("FAIL b2b_accept_cycle: accept at %0d required %0d", last_acc, hs1 + 1);
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (acc_cnt - acc0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d pending=%0d required 2 0", acc_cnt - acc0, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      rk_a[i] = '0;
      rk_b[i] = '0;
    end
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_aes256();
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_enc_round_ctrl.md
Name: aes_enc_round_ctrl

Overview:
Iterative AES encryption engine. It holds the 128-bit state register and sequences one full round per clock through a combinational round datapath built around aes_mixcolumns. It has valid/ready handshakes on block input and output. Round keys come from an external key store, addressed by a round index this block drives. It sits between the host-side block interface and the key-expansion/key-store logic.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal range 10..14
RKW, 4, round index width; must satisfy 2**RKW > NR

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_block is valid
in_ready  out  1  block can be accepted this cycle
in_block  in  128  plaintext; [127:120] = FIPS-197 byte 0, column-major
rk_idx  out  RKW  round-key index requested this cycle
rk  in  128  round key for rk_idx; combinational from key store, valid in the same cycle
out_valid  out  1  out_block holds ciphertext
out_ready  in  1  consumer accepts out_block
out_block  out  128  ciphertext, same byte order as in_block
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; state_reg=0; round_cnt=0; in_ready=1; out_valid=0; out_block=0; busy=0; rk_idx=0.
- Reset asserted mid-operation aborts the block. No partial result is ever presented.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - rk_idx=0, in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_block ^ rk; round_cnt <= 1; go to ROUND.
- ROUND:
  - rk_idx=round_cnt.
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk); round_cnt++.
  - When round_cnt==NR-1, go to FINAL; otherwise stay in ROUND.
- FINAL:
  - rk_idx=NR.
  - state_reg <= SubBytes/ShiftRows/AddRoundKey with MixColumns bypassed; go to DONE.
- DONE:
  - out_valid=1, out_block=state_reg.
  - out_block is stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency: accept at edge T, out_valid high after edge T+NR. That is NR+1 cycles of busy for NR=10, from accept to the first out_valid cycle.
- Peak throughput: one block per NR+2 cycles. in_ready=0 in ROUND/FINAL/DONE; no accept-on-drain overlap.
- in_valid while busy: ignored; in_block is not sampled.
- in_block and rk changes outside the sampling cycle have no effect.
- out_ready while out_valid=0: ignored.
- round_cnt never exceeds NR. rk_idx never exceeds NR in any state.
- out_block is driven by state_reg in all states. Consumers must qualify it with out_valid; the value is don't-care when out_valid=0.

Decomposition:
- aes_pkg:
  - aes_state_t (logic [127:0]), rk_idx_t.
  - FSM enum {IDLE, ROUND, FINAL, DONE}.
  - sbox function (256-entry constant table).
  - shift_rows function.
- Sub-module aes_round_dp, purely combinational:
  - inputs state, rk, final_rnd; output next_state.
  - 16 sbox lookups, shift_rows, aes_mixcolumns instance, mux bypassing mixcolumns when final_rnd, XOR with rk.
- The controller contains only the FSM, round counter, state register and handshakes.

Test Plan:
- Bench key-store model supplies rk combinationally from rk_idx.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32. out_valid first high exactly 11 cycles after accept. state_reg after the first ROUND edge = a49c7ff2689f352b6b5bea43026a5049.
- FIPS-197 App. C.1: key 000102...0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. NR=14 with the App. C.3 key 000102...1f -> 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid stays 1, out_block constant, in_ready=0. Then one out_ready pulse -> out_valid=0 and in_ready=1 next cycle.
- Input while busy: toggle in_valid with a different in_block every cycle during ROUND -> result still equals the first block's ciphertext, and exactly one block is accepted.
- Reset mid-round: assert rst_n=0 asynchronously at round 5 -> outputs immediately at reset values. After release, the App. B vector completes correctly with no stale out_valid.
- Back-to-back: two blocks with in_valid held high and out_ready=1 -> second accept occurs the cycle after the first out_valid handshake. Both ciphertexts are correct and in order.
